// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and constants for the RAM access arbiter.
//   state_t            : arbiter FSM state encoding
//   PORT_DMA/PORT_CPU  : requester identifiers used for grant bookkeeping
//   DEFAULT_IDLE_ADDR  : parked address (misaligned, so memory does nothing)
//   ALIGN_BITS         : number of low address bits that must be zero
//   is_misaligned()    : alignment test on the low address bits
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic PORT_DMA = 1'b0;
    localparam logic PORT_CPU = 1'b1;

    localparam logic [63:0] DEFAULT_IDLE_ADDR = 64'h1;

    localparam int ALIGN_BITS = 5;

    // Addresses are bit indices: a 32-bit word starts on a multiple of 32.
    function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr
// Two-way round-robin picker between the DMA and CPU requesters.
// Purely combinational; the caller owns the last_grant register.
// Ports:
//   dma_req     in  : DMA request
//   cpu_req     in  : CPU request
//   last_grant  in  : port granted most recently (PORT_DMA / PORT_CPU)
//   grant_valid out : at least one request is pending
//   grant_id    out : port to grant (meaningful only with grant_valid)
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic dma_req,
    input  logic cpu_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = dma_req | cpu_req;
        grant_id    = PORT_DMA;
        if (dma_req && cpu_req) begin
            // Tie: the port that did not win last time goes first.
            grant_id = (last_grant == PORT_DMA) ? PORT_CPU : PORT_DMA;
        end else if (cpu_req) begin
            grant_id = PORT_CPU;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one address-triggered memory port between the DMA engine and the
// CPU register path. Each access drives the address for one cycle, captures
// read data, then parks the address at IDLE_ADDR so the next access (even to
// the same address) produces an address change. All outputs are registered.
//
// Optional feature macro: RAM_ARB_GRANT_CNT_EN
//   defined   : saturating per-port grant counters on dma/cpu_grant_cnt
//   undefined : counter outputs tied to zero, no counter registers
//
// Ports:
//   clk, reset                 : clock (rising edge), synchronous active-high reset
//   dma_req/we/addr/wdata      : DMA command (req held until dma_ack)
//   dma_ack/rdata/err          : DMA one-cycle response
//   cpu_req/we/addr/wdata      : CPU command (req held until cpu_ack)
//   cpu_ack/rdata/err          : CPU one-cycle response
//   mem_address/data_in/write  : memory command
//   mem_data_out               : memory read data
//   busy                       : FSM outside IDLE
//   dma_grant_cnt/cpu_grant_cnt: grant counters (optional feature)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | parked; sample requests, pick winner, latch command
// ISSUE   | winner's address/data/write on the memory port for one cycle
// CAPTURE | read data latched, memory port parked again
// RESP    | one-cycle ack (with rdata/err) to the granted port
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(DEFAULT_IDLE_ADDR),
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,

    output logic              busy,
    output logic [CNT_W-1:0]  dma_grant_cnt,
    output logic [CNT_W-1:0]  cpu_grant_cnt
);

    state_t state, state_nxt;

    logic grant_valid;
    logic grant_id;
    logic last_grant, last_grant_nxt;
    logic cmd_port,   cmd_port_nxt;
    logic cmd_we,     cmd_we_nxt;

    logic [DATA_W-1:0] resp_rdata, resp_rdata_nxt;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_misaligned;

    logic [ADDR_W-1:0] mem_address_nxt;
    logic [DATA_W-1:0] mem_data_in_nxt;
    logic              mem_write_nxt;
    logic              dma_ack_nxt, cpu_ack_nxt;
    logic              dma_err_nxt, cpu_err_nxt;
    logic [DATA_W-1:0] dma_rdata_nxt, cpu_rdata_nxt;
    logic              busy_nxt;

    logic              resp_fire;
    logic              resp_port;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    ram_arb_rr u_rr (
        .dma_req     (dma_req),
        .cpu_req     (cpu_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Winner's command, muxed straight from the request ports.
    always_comb begin
        if (grant_id == PORT_DMA) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end else begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end
        sel_misaligned = is_misaligned(sel_addr[ALIGN_BITS-1:0]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = sel_misaligned ? RESP : ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and command latches.
    always_comb begin
        mem_address_nxt = mem_address;
        mem_data_in_nxt = mem_data_in;
        mem_write_nxt   = mem_write;
        last_grant_nxt  = last_grant;
        cmd_port_nxt    = cmd_port;
        cmd_we_nxt      = cmd_we;
        resp_rdata_nxt  = resp_rdata;

        resp_fire = 1'b0;
        resp_port = cmd_port;
        resp_err  = 1'b0;
        resp_data = '0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    last_grant_nxt = grant_id;
                    cmd_port_nxt   = grant_id;
                    cmd_we_nxt     = sel_we;
                    resp_rdata_nxt = '0;
                    if (sel_misaligned) begin
                        // Memory is never touched; answer straight away.
                        resp_fire = 1'b1;
                        resp_port = grant_id;
                        resp_err  = 1'b1;
                    end else begin
                        mem_address_nxt = sel_addr;
                        mem_write_nxt   = sel_we;
                        mem_data_in_nxt = sel_wdata;
                    end
                end
            end
            ISSUE: begin
                // Memory has evaluated the address change during ISSUE; grab
                // its result and park the port on the same edge.
                mem_address_nxt = IDLE_ADDR;
                mem_write_nxt   = 1'b0;
                mem_data_in_nxt = '0;
                resp_rdata_nxt  = cmd_we ? '0 : mem_data_out;
            end
            CAPTURE: begin
                resp_fire = 1'b1;
                resp_port = cmd_port;
                resp_data = resp_rdata;
            end
            default: begin
            end
        endcase

        dma_ack_nxt   = 1'b0;
        dma_err_nxt   = 1'b0;
        dma_rdata_nxt = '0;
        cpu_ack_nxt   = 1'b0;
        cpu_err_nxt   = 1'b0;
        cpu_rdata_nxt = '0;
        if (resp_fire) begin
            if (resp_port == PORT_DMA) begin
                dma_ack_nxt   = 1'b1;
                dma_err_nxt   = resp_err;
                dma_rdata_nxt = resp_data;
            end else begin
                cpu_ack_nxt   = 1'b1;
                cpu_err_nxt   = resp_err;
                cpu_rdata_nxt = resp_data;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address <= IDLE_ADDR;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            dma_ack     <= 1'b0;
            dma_err     <= 1'b0;
            dma_rdata   <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rdata   <= '0;
            busy        <= 1'b0;
            last_grant  <= PORT_CPU;
            cmd_port    <= PORT_DMA;
            cmd_we      <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            mem_address <= mem_address_nxt;
            mem_data_in <= mem_data_in_nxt;
            mem_write   <= mem_write_nxt;
            dma_ack     <= dma_ack_nxt;
            dma_err     <= dma_err_nxt;
            dma_rdata   <= dma_rdata_nxt;
            cpu_ack     <= cpu_ack_nxt;
            cpu_err     <= cpu_err_nxt;
            cpu_rdata   <= cpu_rdata_nxt;
            busy        <= busy_nxt;
            last_grant  <= last_grant_nxt;
            cmd_port    <= cmd_port_nxt;
            cmd_we      <= cmd_we_nxt;
            resp_rdata  <= resp_rdata_nxt;
        end
    end

`ifdef RAM_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] dma_cnt;
    logic [CNT_W-1:0] cpu_cnt;

    // Counts every grant, misaligned ones included; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_cnt <= '0;
            cpu_cnt <= '0;
        end else if (state == IDLE && grant_valid) begin
            if (grant_id == PORT_DMA) begin
                if (dma_cnt != '1) dma_cnt <= dma_cnt + 1'b1;
            end else begin
                if (cpu_cnt != '1) cpu_cnt <= cpu_cnt + 1'b1;
            end
        end
    end

    assign dma_grant_cnt = dma_cnt;
    assign cpu_grant_cnt = cpu_cnt;
`else
    assign dma_grant_cnt = '0;
    assign cpu_grant_cnt = '0;
`endif

endmodule
